bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential double-dabble converter that consumes the 16-bit ALU result bus (led_out) and produces packed BCD digits for the calculator's 7-segment display driver.
- Sits directly downstream of the 8-bit ALU top.
- Optional signed mode presents SUB results as sign plus magnitude.
- Start/busy/done handshake, so the display stage re-samples only when a new result is available.

Parameters:
- WIDTH, 16, binary input width in bits.
- DIGITS, 5, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- bin_in  input  WIDTH  binary value to convert; sampled only on the accept edge
- signed_en  input  1  1 = treat bin_in as two's complement; sampled with bin_in
- start  input  1  conversion request; level-sampled
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse; bcd_out/neg_out are valid from this cycle onward
- bcd_out  output  4*DIGITS  packed BCD, digit 0 in bits [3:0] (least significant)
- neg_out  output  1  sign of the last converted value (1 = negative)

Behaviour:
- Reset values (asynchronous, takes effect immediately):
  - state=IDLE
  - busy=0, done=0
  - bcd_out=0, neg_out=0
  - internal shift register and counter = 0
- Reset asserted mid-conversion aborts the conversion. No done pulse is issued. Outputs return to reset values.
- States:
  - IDLE: wait for start.
  - CONV: one iteration per cycle.
  - DONE: one cycle, then return to IDLE.
- Accept rule:
  - start=1 at a rising edge while state is IDLE or DONE (i.e. busy=0) accepts a request.
  - start while busy=1 is ignored, not queued.
- Accept edge (edge k):
  - Capture mag and neg:
    - If signed_en=1 and bin_in[WIDTH-1]=1: mag = (~bin_in + 1) taken as a WIDTH-bit unsigned value, neg=1.
    - Otherwise: mag = bin_in, neg=0.
  - 0x8000 signed converts to magnitude 32768.
  - Load scratch = {DIGITS*4 zeros, mag}, cnt=0, state=CONV, busy=1.
- Each CONV edge:
  - For every BCD digit field in scratch: if the digit is >= 5, add 3 (combinational).
  - Then shift the whole scratch left by 1.
  - cnt increments.
- The edge performing iteration WIDTH (edge k+WIDTH):
  - bcd_out <= final digit field, neg_out <= captured neg.
  - state=DONE, done=1, busy=0.
- Latency: done is high in the cycle after edge k+WIDTH. That is WIDTH cycles after the accept edge (16 for the default).
- DONE cycle:
  - done=1 for exactly one cycle.
  - If start=1 at the end of this cycle, a new conversion is accepted (back-to-back throughput: WIDTH+1 cycles per result). Otherwise go to IDLE.
- bcd_out/neg_out hold their value between conversions. They are updated only at the final-iteration edge, never mid-conversion.
- bin_in and signed_en changes while busy=1 have no effect.
- Digits never exceed 9. No overflow is possible when the DIGITS constraint holds.

Decomposition:
- Shared package (calc_pkg):
  - BCD_DIGIT_W=4.
  - State encodings IDLE/CONV/DONE (2-bit).
  - Clog2 helper for the cnt width.
  - Default WIDTH/DIGITS constants shared with the display driver.
- Sub-module bcd_add3 (combinational, 4-bit in/out, add 3 when input >= 5). Instantiated DIGITS times via generate.

Test Plan:
- Reset, then bin_in=0x0013, signed_en=0, start pulse:
  - busy high for 16 cycles.
  - done pulses exactly 16 cycles after the accept edge.
  - bcd_out=0x00019, neg_out=0.
- bin_in=0x0096 (ALU MUL 15*10): bcd_out=0x00150. Then bin_in=0xFFFF: bcd_out=0x65535, neg_out=0.
- signed_en=1, bin_in=0xFFFB: bcd_out=0x00005, neg_out=1. Then bin_in=0x8000: bcd_out=0x32768, neg_out=1.
- signed_en=0, bin_in=0xFFFB: bcd_out=0x65531, neg_out=0 (signed mode off ignores the MSB).
- Start bin_in=0x0064. Drive start=1 with bin_in=0x1234 on cycles 3-5 of busy:
  - Only one done pulse.
  - bcd_out=0x00100.
  - Holding start=1 in the done cycle launches 0x1234 immediately → bcd_out=0x04660 after a further 16 cycles.
- Assert rst for 1 cycle at iteration 8 of converting 0x0100:
  - busy=0 and bcd_out=0 immediately.
  - No done pulse.
  - A new start afterwards converts correctly.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: BCD digit width, converter
// state encoding, a ceiling-log2 helper and the default bus sizes that the
// display driver also relies on.
package calc_pkg;

    localparam int BCD_DIGIT_W    = 4;
    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_DIGITS = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of bits needed to hold values 0 .. value-1 (minimum 1).
    function automatic int calc_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
module bcd_add3
    import calc_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    // Add 3 to digits 5..9 before they are doubled by the shift.
    always_comb begin
        adjusted = digit;
        if (digit >= BCD_DIGIT_W'(5)) begin
            adjusted = digit + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with optional sign and
// magnitude handling. One bit is shifted per clock; a start/busy/done
// handshake lets the display stage re-sample only on fresh results.
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              bin_in,
    input  logic                          signed_en,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [DIGITS*BCD_DIGIT_W-1:0] bcd_out,
    output logic                          neg_out
);

    localparam int BCD_W = DIGITS * BCD_DIGIT_W;
    localparam int SCR_W = BCD_W + WIDTH;
    localparam int CNT_W = calc_clog2(WIDTH + 1);

    state_t             state;
    logic [SCR_W-1:0]   scratch;
    logic [CNT_W-1:0]   cnt;
    logic               neg;

    logic [BCD_W-1:0]   adj_digits;
    logic [SCR_W-1:0]   shifted;
    logic [WIDTH-1:0]   mag_next;
    logic               neg_next;
    logic               last_iter;

    // One correction cell per BCD digit field sitting above the binary part.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .digit    (scratch[WIDTH + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (adj_digits[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign shifted   = {adj_digits, scratch[WIDTH-1:0]} << 1;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Magnitude and sign of the incoming value; the most negative code maps
    // to its full unsigned magnitude because the result is kept WIDTH bits.
    always_comb begin
        neg_next = signed_en & bin_in[WIDTH-1];
        mag_next = bin_in;
        if (neg_next) begin
            mag_next = (~bin_in) + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Control FSM and datapath: accept when not busy, iterate WIDTH times,
    // publish the digits on the last iteration and pulse done for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            scratch <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            neg_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        scratch <= {{BCD_W{1'b0}}, mag_next};
                        neg     <= neg_next;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end else begin
                        state   <= IDLE;
                    end
                end
                CONV: begin
                    scratch <= shifted;
                    cnt     <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        bcd_out <= shifted[SCR_W-1:WIDTH];
                        neg_out <= neg;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed handshake scenarios plus
// randomized conversions compared against a decimal-arithmetic model.
module tb_bin2bcd_seq;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [WIDTH-1:0]    bin_in;
    logic                signed_en;
    logic                start;
    logic                busy;
    logic                done;
    logic [DIGITS*4-1:0] bcd_out;
    logic                neg_out;

    int n_asserts = 0;
    int n_fail    = 0;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bin_in    (bin_in),
        .signed_en (signed_en),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .bcd_out   (bcd_out),
        .neg_out   (neg_out)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Decimal digits of a magnitude, least significant digit in bits [3:0].
    function automatic logic [DIGITS*4-1:0] refBcd(input int unsigned value);
        logic [DIGITS*4-1:0] r;
        int unsigned v;
        r = '0;
        v = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] value, input logic sgn,
                                 input logic strt);
        bin_in    = value;
        signed_en = sgn;
        start     = strt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one conversion, scramble inputs while busy, then check latency,
    // busy coverage, the result and the single-cycle done pulse.
    task automatic runConversion(input logic [WIDTH-1:0] value, input logic sgn,
                                 input string tag, output logic [DIGITS*4-1:0] exp_bcd);
        int unsigned mag;
        logic        exp_neg;
        int          cycles;
        logic        busy_gap;
        exp_neg  = sgn & value[WIDTH-1];
        mag      = exp_neg ? (32'h10000 - 32'(value)) : 32'(value);
        exp_bcd  = refBcd(mag);
        applyStimulus(value, sgn, 1'b1);
        tick();
        applyStimulus(16'($urandom), 1'($urandom), 1'b0);
        checkOutput({tag, " busy after accept"}, 32'(busy), 32'd1);
        cycles   = 0;
        busy_gap = 1'b0;
        while (done !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
            if (done !== 1'b1 && busy !== 1'b1) busy_gap = 1'b1;
        end
        checkOutput({tag, " latency"}, 32'(cycles), 32'(WIDTH));
        checkOutput({tag, " busy gap"}, 32'(busy_gap), 32'd0);
        checkOutput({tag, " busy in done"}, 32'(busy), 32'd0);
        checkOutput({tag, " bcd"}, 32'(bcd_out), 32'(exp_bcd));
        checkOutput({tag, " neg"}, 32'(neg_out), 32'(exp_neg));
        tick();
        checkOutput({tag, " done width"}, 32'(done), 32'd0);
    endtask

    initial begin : main
        logic [DIGITS*4-1:0] last_bcd;
        int                  cycles;
        int                  pulses;
        logic [WIDTH-1:0]    rv;
        logic                rs;

        rst = 1'b1;
        applyStimulus('0, 1'b0, 1'b0);
        repeat (2) tick();
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset bcd", 32'(bcd_out), 32'd0);
        checkOutput("reset neg", 32'(neg_out), 32'd0);
        rst = 1'b0;
        tick();

        runConversion(16'h0013, 1'b0, "u19", last_bcd);
        checkOutput("u19 literal", 32'(bcd_out), 32'h00019);
        runConversion(16'h0096, 1'b0, "u150", last_bcd);
        checkOutput("u150 literal", 32'(bcd_out), 32'h00150);
        runConversion(16'hFFFF, 1'b0, "u65535", last_bcd);
        checkOutput("u65535 literal", 32'(bcd_out), 32'h65535);
        runConversion(16'hFFFB, 1'b1, "s-5", last_bcd);
        checkOutput("s-5 literal", 32'(bcd_out), 32'h00005);
        runConversion(16'h8000, 1'b1, "s-32768", last_bcd);
        checkOutput("s-32768 literal", 32'(bcd_out), 32'h32768);
        runConversion(16'hFFFB, 1'b0, "u65531", last_bcd);
        checkOutput("u65531 literal", 32'(bcd_out), 32'h65531);

        // Outputs must hold while idle even as the inputs wander.
        applyStimulus(16'h4321, 1'b1, 1'b0);
        repeat (5) tick();
        checkOutput("hold bcd", 32'(bcd_out), 32'(last_bcd));
        checkOutput("hold neg", 32'(neg_out), 32'd0);

        // Start requests during busy are ignored; start held into the done
        // cycle launches the next conversion immediately.
        applyStimulus(16'h0064, 1'b0, 1'b1);
        tick();
        applyStimulus(16'h0064, 1'b0, 1'b0);
        repeat (2) tick();
        applyStimulus(16'h1234, 1'b0, 1'b1);
        cycles = 2;
        while (done !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        checkOutput("b2b first latency", 32'(cycles), 32'(WIDTH));
        checkOutput("b2b first bcd", 32'(bcd_out), 32'(refBcd(100)));
        tick();
        applyStimulus(16'h1234, 1'b0, 1'b0);
        checkOutput("b2b relaunch busy", 32'(busy), 32'd1);
        checkOutput("b2b relaunch done", 32'(done), 32'd0);
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        checkOutput("b2b second latency", 32'(cycles), 32'(WIDTH));
        checkOutput("b2b second bcd", 32'(bcd_out), 32'h04660);
        tick();

        // Reset in the middle of a conversion aborts it without a done pulse.
        applyStimulus(16'h0100, 1'b0, 1'b1);
        tick();
        applyStimulus(16'h0100, 1'b0, 1'b0);
        repeat (8) tick();
        rst = 1'b1;
        #1;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort bcd", 32'(bcd_out), 32'd0);
        checkOutput("abort neg", 32'(neg_out), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        checkOutput("abort no done", 32'(pulses), 32'd0);
        runConversion(16'h0100, 1'b0, "after abort", last_bcd);

        // Randomized conversions against the decimal model.
        for (int i = 0; i < 12; i++) begin
            rv = 16'($urandom);
            rs = 1'($urandom);
            runConversion(rv, rs, $sformatf("rand%0d", i), last_bcd);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
